alu_regfile_pipe: RTL and testbench

ALU_REGFILE_PIPE -- requirements
Module: alu_regfile_pipe

---
 rtl/alu_regfile_pipe_if.sv | 30 +++
 rtl/alu_regfile_pipe.sv | 142 ++++++++++++++
 tb/tb_alu_regfile_pipe.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/alu_regfile_pipe_if.sv
// Instruction-in / result-out bundle for alu_regfile_pipe.
// master drives instructions and out_ready; slave is the pipeline.
interface alu_regfile_pipe_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [AW-1:0]    rd;
    logic             wb_en;
    logic [WIDTH-1:0] ld_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;

    modport master (
        output in_valid, op, rs1, rs2, rd, wb_en, ld_data, out_ready,
        input  in_ready, out_valid, result, zero, carry
    );

    modport slave (
        input  in_valid, op, rs1, rs2, rd, wb_en, ld_data, out_ready,
        output in_ready, out_valid, result, zero, carry
    );
endinterface

// File: rtl/alu_regfile_pipe.sv
// Register file feeding a two-stage ALU pipe (S1 operand register, EX output register).
// Latency: accepted at edge k, result valid after edge k+1; write-back happens as the op enters EX.
// Backpressure: out_ready low stalls EX, then S1; in_ready drops only when both are full and stalled.
module alu_regfile_pipe #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    alu_regfile_pipe_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_SLL  = 3'b010,
        OP_SRL  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_LOAD = 3'b111
    } op_e;

    logic [WIDTH-1:0] regs [DEPTH];

    logic             s1_vld;
    op_e              s1_op;
    logic [AW-1:0]    s1_rd;
    logic             s1_wb;
    logic [WIDTH-1:0] s1_ld;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             out_vld;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             carry_q;

    logic             ex_adv;
    logic             accept;
    logic             wr_en;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    assign ex_adv       = s1_vld && (!out_vld || bus.out_ready);
    assign bus.in_ready = reset_n && (!s1_vld || ex_adv);
    assign accept       = bus.in_valid && bus.in_ready;
    assign wr_en        = ex_adv && s1_wb && !((ZERO_REG != 0) && (s1_rd == '0));

    always_comb begin
        wide      = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (s1_op)
            OP_ADD: begin
                wide      = {1'b0, s1_a} + {1'b0, s1_b};
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
            end
            // The extra top bit of the widened difference is the borrow.
            OP_SUB: begin
                wide      = {1'b0, s1_a} - {1'b0, s1_b};
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
            end
            OP_SLL:  alu_res = (s1_b >= SHIFT_LIM) ? '0 : (s1_a << s1_b);
            OP_SRL:  alu_res = (s1_b >= SHIFT_LIM) ? '0 : (s1_a >> s1_b);
            OP_AND:  alu_res = s1_a & s1_b;
            OP_OR:   alu_res = s1_a | s1_b;
            OP_XOR:  alu_res = s1_a ^ s1_b;
            OP_LOAD: alu_res = s1_ld;
            default: alu_res = '0;
        endcase
    end

    // Operand read with bypass of the write landing on this same edge.
    always_comb begin
        opa = regs[bus.rs1];
        opb = regs[bus.rs2];
        if (wr_en && (s1_rd == bus.rs1)) opa = alu_res;
        if (wr_en && (s1_rd == bus.rs2)) opb = alu_res;
        if ((ZERO_REG != 0) && (bus.rs1 == '0)) opa = '0;
        if ((ZERO_REG != 0) && (bus.rs2 == '0)) opb = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld <= 1'b0;
            s1_op  <= OP_ADD;
            s1_rd  <= '0;
            s1_wb  <= 1'b0;
            s1_ld  <= '0;
            s1_a   <= '0;
            s1_b   <= '0;
        end else if (accept) begin
            s1_vld <= 1'b1;
            s1_op  <= op_e'(bus.op);
            s1_rd  <= bus.rd;
            s1_wb  <= bus.wb_en;
            s1_ld  <= bus.ld_data;
            s1_a   <= opa;
            s1_b   <= opb;
        end else if (ex_adv) begin
            s1_vld <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_vld <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (ex_adv) begin
            out_vld <= 1'b1;
            res_q   <= alu_res;
            zero_q  <= (alu_res == '0);
            carry_q <= alu_carry;
        end else if (bus.out_ready) begin
            out_vld <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[s1_rd] <= alu_res;
        end
    end

    assign bus.out_valid = out_vld;
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed bench for alu_regfile_pipe: inputs change on the falling edge, outputs are sampled there too.
module tb_alu_regfile_pipe;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, SLL = 3'b010, SRL = 3'b011, LOAD = 3'b111;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_regfile_pipe_if #(.WIDTH(32), .AW(5)) bus();

    alu_regfile_pipe #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic set_instr(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic wb, input logic [31:0] ld);
        bus.op = op; bus.rs1 = rs1; bus.rs2 = rs2; bus.rd = rd; bus.wb_en = wb; bus.ld_data = ld;
    endtask

    // Present one instruction for one edge; returns on the following falling edge.
    task automatic send(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wb, input logic [31:0] ld);
        set_instr(op, rs1, rs2, rd, wb, ld);
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    // Send and wait until that instruction's result is on the output.
    task automatic exec(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wb, input logic [31:0] ld);
        send(op, rs1, rs2, rd, wb, ld);
        @(negedge clock);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        set_instr(ADD, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL rst_result got=%h exp=0", bus.result); end
        checks++; if (bus.zero !== 1'b0 || bus.carry !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", bus.zero, bus.carry); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready_low got=%b exp=0", bus.in_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready_after got=%b exp=1", bus.in_ready); end
        @(negedge clock);
        exec(ADD, 5'd1, 5'd0, 5'd0, 1'b0, 32'h0);
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h0) begin failures++; $display("FAIL rst_reg_clear got=%b/%h exp=1/0", bus.out_valid, bus.result); end
    endtask

    task automatic test_load_add();
        send(LOAD, 0, 0, 5'd1, 1'b1, 32'd5);
        send(LOAD, 0, 0, 5'd2, 1'b1, 32'd7);
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd5) begin failures++; $display("FAIL la_load1 got=%b/%h exp=1/5", bus.out_valid, bus.result); end
        send(ADD, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0);
        checks++; if (bus.result !== 32'd7) begin failures++; $display("FAIL la_load2 got=%h exp=7", bus.result); end
        @(negedge clock);
        checks++; if (bus.result !== 32'd12 || bus.carry !== 1'b0 || bus.zero !== 1'b0) begin failures++; $display("FAIL la_add got=%h c=%b z=%b exp=c 0 0", bus.result, bus.carry, bus.zero); end
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL la_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        send(LOAD, 0, 0, 5'd4, 1'b1, 32'hFFFF_FFFF);
        send(ADD, 5'd4, 5'd4, 5'd5, 1'b1, 32'h0);
        checks++; if (bus.result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL b2b_load got=%h exp=ffffffff", bus.result); end
        @(negedge clock);
        checks++; if (bus.result !== 32'hFFFF_FFFE || bus.carry !== 1'b1 || bus.zero !== 1'b0) begin failures++; $display("FAIL b2b_add got=%h c=%b z=%b exp=fffffffe 1 0", bus.result, bus.carry, bus.zero); end
        exec(ADD, 5'd5, 5'd0, 5'd0, 1'b0, 32'h0);
        checks++; if (bus.result !== 32'hFFFF_FFFE || bus.carry !== 1'b0) begin failures++; $display("FAIL b2b_r5 got=%h c=%b exp=fffffffe 0", bus.result, bus.carry); end
    endtask

    task automatic test_backpressure();
        @(negedge clock);
        bus.out_ready = 1'b0;
        set_instr(LOAD, 0, 0, 5'd16, 1'b1, 32'h11);
        bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_first got=%b exp=1", bus.in_ready); end
        @(negedge clock);
        set_instr(LOAD, 0, 0, 5'd17, 1'b1, 32'h22);
        @(negedge clock);
        set_instr(LOAD, 0, 0, 5'd18, 1'b1, 32'h33);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_drop got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h11) begin failures++; $display("FAIL bp_first_out got=%b/%h exp=1/11", bus.out_valid, bus.result); end
        @(negedge clock);
        #1;
        checks++; if (bus.result !== 32'h11 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_stable got=%h rdy=%b exp=11 0", bus.result, bus.in_ready); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", bus.in_ready); end
        @(negedge clock);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h22) begin failures++; $display("FAIL bp_second got=%b/%h exp=1/22", bus.out_valid, bus.result); end
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'h33) begin failures++; $display("FAIL bp_third got=%b/%h exp=1/33", bus.out_valid, bus.result); end
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", bus.out_valid); end
        exec(ADD, 5'd17, 5'd18, 5'd0, 1'b0, 32'h0);
        checks++; if (bus.result !== 32'h55) begin failures++; $display("FAIL bp_writes got=%h exp=55", bus.result); end
    endtask

    task automatic test_boundaries();
        exec(LOAD, 0, 0, 5'd8, 1'b1, 32'd3);
        exec(LOAD, 0, 0, 5'd9, 1'b1, 32'd5);
        exec(LOAD, 0, 0, 5'd10, 1'b1, 32'd4);
        exec(LOAD, 0, 0, 5'd11, 1'b1, 32'd1);
        exec(LOAD, 0, 0, 5'd12, 1'b1, 32'd32);
        exec(LOAD, 0, 0, 5'd13, 1'b1, 32'h8000_0000);
        exec(LOAD, 0, 0, 5'd14, 1'b1, 32'd31);
        exec(SUB, 5'd8, 5'd9, 5'd15, 1'b1, 32'h0);
        checks++; if (bus.result !== 32'hFFFF_FFFE || bus.carry !== 1'b1 || bus.zero !== 1'b0) begin failures++; $display("FAIL sub_borrow got=%h c=%b z=%b exp=fffffffe 1 0", bus.result, bus.carry, bus.zero); end
        exec(SUB, 5'd10, 5'd10, 5'd15, 1'b1, 32'h0);
        checks++; if (bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.carry !== 1'b0) begin failures++; $display("FAIL sub_zero got=%h z=%b c=%b exp=0 1 0", bus.result, bus.zero, bus.carry); end
        exec(SLL, 5'd11, 5'd12, 5'd0, 1'b0, 32'h0);
        checks++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin failures++; $display("FAIL sll_32 got=%h z=%b exp=0 1", bus.result, bus.zero); end
        exec(SLL, 5'd11, 5'd14, 5'd0, 1'b0, 32'h0);
        checks++; if (bus.result !== 32'h8000_0000) begin failures++; $display("FAIL sll_31 got=%h exp=80000000", bus.result); end
        exec(SRL, 5'd13, 5'd14, 5'd0, 1'b0, 32'h0);
        checks++; if (bus.result !== 32'h1 || bus.carry !== 1'b0) begin failures++; $display("FAIL srl_31 got=%h c=%b exp=1 0", bus.result, bus.carry); end
    endtask

    task automatic test_zero_reg();
        exec(LOAD, 0, 0, 5'd0, 1'b1, 32'd9);
        checks++; if (bus.result !== 32'd9) begin failures++; $display("FAIL r0_load_out got=%h exp=9", bus.result); end
        exec(ADD, 5'd0, 5'd0, 5'd6, 1'b1, 32'h0);
        checks++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin failures++; $display("FAIL r0_read got=%h z=%b exp=0 1", bus.result, bus.zero); end
        send(LOAD, 0, 0, 5'd0, 1'b1, 32'd9);
        send(ADD, 5'd0, 5'd0, 5'd6, 1'b1, 32'h0);
        @(negedge clock);
        checks++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin failures++; $display("FAIL r0_bypass got=%h z=%b exp=0 1", bus.result, bus.zero); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clock);
        bus.out_ready = 1'b0;
        set_instr(LOAD, 0, 0, 5'd7, 1'b1, 32'hAB);
        bus.in_valid = 1'b1;
        @(negedge clock);
        set_instr(LOAD, 0, 0, 5'd7, 1'b1, 32'hCD);
        @(negedge clock);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'hAB) begin failures++; $display("FAIL mid_pre got=%b/%h exp=1/ab", bus.out_valid, bus.result); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_async got=%b/%h rdy=%b exp=0/0 0", bus.out_valid, bus.result, bus.in_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_no_replay got=%b exp=0", bus.out_valid); end
        exec(ADD, 5'd7, 5'd0, 5'd0, 1'b0, 32'h0);
        checks++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin failures++; $display("FAIL mid_r7 got=%h z=%b exp=0 1", bus.result, bus.zero); end
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_back_to_back();
        test_backpressure();
        test_boundaries();
        test_zero_reg();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
